instr_fetch_unit: RTL and testbench

//  Parametrised multicycle instruction fetch for the narrow-bus datapath. It assembles one

---
 rtl/instr_fetch_unit.sv | 92 +++++++++
 tb/tb_instr_fetch_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch: assembles INSTR_W bits from INSTR_W/DATA_W memory beats,
// owns the PC, and presents the instruction to decode under a valid/ready handshake.
module instr_fetch_unit #(
  parameter int                DATA_W   = 8,
  parameter int                INSTR_W  = 32,
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_adr,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ready,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy
);

  localparam int BEATS  = INSTR_W / DATA_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t            state, next_state;
  logic [BEAT_W-1:0] beat;
  logic              beat_done;
  logic              last_beat;

  assign beat_done = (state == FETCH) && mem_ready;
  assign last_beat = (beat == LAST_BEAT);

  // NOTE: state and datapath registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state gets its hold value first so no path through the case leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    if (redirect) begin
      next_state = en ? FETCH : IDLE;
    end else begin
      case (state)
        IDLE:    if (en) next_state = FETCH;
        FETCH:   if (mem_ready && last_beat) next_state = HOLD;
        HOLD:    if (instr_ready) next_state = en ? FETCH : IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Redirect wins over a beat returned in the same cycle: the beat is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      beat        <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else if (redirect) begin
      pc          <= redirect_pc;
      beat        <= '0;
      instr_valid <= 1'b0;
    end else begin
      if (beat_done) begin
        instr[int'(beat)*DATA_W +: DATA_W] <= mem_rdata;
        if (last_beat) begin
          beat        <= '0;
          pc          <= pc + ADDR_W'(BEATS);
          instr_valid <= 1'b1;
        end else begin
          beat <= beat + BEAT_W'(1);
        end
      end
      if (state == HOLD && instr_ready) instr_valid <= 1'b0;
    end
  end

  assign mem_rd  = (state == FETCH);
  assign mem_adr = pc + ADDR_W'(beat);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: an 8-bit-bus instance for the main scenarios and a
// 16-bit-bus instance (non-zero RESET_PC) for the wide-beat and async-reset cases.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 8-bit data bus instance
  logic        en, redirect, mem_ready, instr_ready;
  logic [7:0]  redirect_pc;
  logic        mem_rd, instr_valid, busy;
  logic [7:0]  mem_adr, pc, mem_rdata;
  logic [31:0] instr;
  logic [7:0]  mem [256];
  assign mem_rdata = mem[mem_adr];

  instr_fetch_unit #(.DATA_W(8), .INSTR_W(32), .ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .en(en), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_rd(mem_rd), .mem_adr(mem_adr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc), .busy(busy)
  );

  // 16-bit data bus instance
  logic        en16, redirect16, mem_ready16, instr_ready16;
  logic [7:0]  redirect_pc16;
  logic        mem_rd16, instr_valid16, busy16;
  logic [7:0]  mem_adr16, pc16;
  logic [15:0] mem_rdata16;
  logic [31:0] instr16;
  logic [15:0] mem16 [256];
  assign mem_rdata16 = mem16[mem_adr16];

  instr_fetch_unit #(.DATA_W(16), .INSTR_W(32), .ADDR_W(8), .RESET_PC(8'h10)) dut16 (
    .clk(clk), .reset(reset), .en(en16), .redirect(redirect16), .redirect_pc(redirect_pc16),
    .mem_rd(mem_rd16), .mem_adr(mem_adr16), .mem_rdata(mem_rdata16), .mem_ready(mem_ready16),
    .instr(instr16), .instr_valid(instr_valid16), .instr_ready(instr_ready16), .pc(pc16),
    .busy(busy16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({mem_rd, instr_valid, busy, pc, instr} !== {1'b0, 1'b0, 1'b0, 8'h00, 32'h0}) begin
      errors++;
      $display("FAIL reset8: rd/vld/busy/pc/instr=%b%b%b/%h/%h want 000/00/00000000",
               mem_rd, instr_valid, busy, pc, instr);
    end
    checks++;
    if ({mem_rd16, instr_valid16, busy16, pc16, instr16} !== {1'b0, 1'b0, 1'b0, 8'h10, 32'h0}) begin
      errors++;
      $display("FAIL reset16: rd/vld/busy/pc/instr=%b%b%b/%h/%h want 000/10/00000000",
               mem_rd16, instr_valid16, busy16, pc16, instr16);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_basic_fetch();
    en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if ({mem_rd, instr_valid, mem_adr} !== {1'b1, 1'b0, 8'(k - 1)}) begin
        errors++;
        $display("FAIL basic_beat%0d: rd/vld/adr=%b%b/%h want 10/%h",
                 k, mem_rd, instr_valid, mem_adr, 8'(k - 1));
      end
    end
    tick();
    checks++;
    if ({instr_valid, mem_rd, instr, pc} !== {1'b1, 1'b0, 32'h00852020, 8'h04}) begin
      errors++;
      $display("FAIL basic_done: vld/rd/instr/pc=%b%b/%h/%h want 10/00852020/04",
               instr_valid, mem_rd, instr, pc);
    end
  endtask

  task automatic test_hold();
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if ({instr_valid, mem_rd, instr, pc} !== {1'b1, 1'b0, 32'h00852020, 8'h04}) begin
        errors++;
        $display("FAIL hold_stable%0d: vld/rd/instr/pc=%b%b/%h/%h want 10/00852020/04",
                 k, instr_valid, mem_rd, instr, pc);
      end
    end
    en = 1'b1;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    checks++;
    if ({mem_rd, instr_valid, mem_adr} !== {1'b1, 1'b0, 8'h04}) begin
      errors++;
      $display("FAIL hold_accept: rd/vld/adr=%b%b/%h want 10/04", mem_rd, instr_valid, mem_adr);
    end
  endtask

  task automatic test_stall();
    redirect = 1'b1;
    redirect_pc = 8'h00;
    tick();
    redirect = 1'b0;
    checks++;
    if ({mem_rd, mem_adr, pc} !== {1'b1, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL stall_restart: rd/adr/pc=%b/%h/%h want 1/00/00", mem_rd, mem_adr, pc);
    end
    tick();
    tick();
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({mem_rd, instr_valid, mem_adr} !== {1'b1, 1'b0, 8'h02}) begin
        errors++;
        $display("FAIL stall_hold%0d: rd/vld/adr=%b%b/%h want 10/02", k, mem_rd, instr_valid, mem_adr);
      end
    end
    mem_ready = 1'b1;
    tick();
    checks++;
    if ({instr_valid, mem_adr} !== {1'b0, 8'h03}) begin
      errors++;
      $display("FAIL stall_beat3: vld/adr=%b/%h want 0/03", instr_valid, mem_adr);
    end
    tick();
    checks++;
    if ({instr_valid, instr, pc} !== {1'b1, 32'h00852020, 8'h04}) begin
      errors++;
      $display("FAIL stall_done: vld/instr/pc=%b/%h/%h want 1/00852020/04", instr_valid, instr, pc);
    end
  endtask

  task automatic test_redirect();
    en = 1'b1;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    tick();
    checks++;
    if (mem_adr !== 8'h05) begin
      errors++;
      $display("FAIL redir_pre: adr=%h want 05", mem_adr);
    end
    redirect = 1'b1;
    redirect_pc = 8'h40;
    tick();
    redirect = 1'b0;
    en = 1'b0;
    checks++;
    if ({mem_rd, instr_valid, mem_adr, pc} !== {1'b1, 1'b0, 8'h40, 8'h40}) begin
      errors++;
      $display("FAIL redir_target: rd/vld/adr/pc=%b%b/%h/%h want 10/40/40",
               mem_rd, instr_valid, mem_adr, pc);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if ({mem_rd, instr_valid, mem_adr} !== {1'b1, 1'b0, 8'(8'h40 + k)}) begin
        errors++;
        $display("FAIL redir_beat%0d: rd/vld/adr=%b%b/%h want 10/%h",
                 k, mem_rd, instr_valid, mem_adr, 8'(8'h40 + k));
      end
    end
    tick();
    checks++;
    if ({instr_valid, instr, pc, busy} !== {1'b1, 32'h04030201, 8'h44, 1'b1}) begin
      errors++;
      $display("FAIL redir_done: vld/instr/pc/busy=%b/%h/%h/%b want 1/04030201/44/1",
               instr_valid, instr, pc, busy);
    end
  endtask

  task automatic test_wrap();
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;
    en = 1'b1;
    redirect = 1'b1;
    redirect_pc = 8'hFE;
    tick();
    redirect = 1'b0;
    checks++;
    if ({mem_rd, instr_valid, mem_adr} !== {1'b1, 1'b0, 8'hFE}) begin
      errors++;
      $display("FAIL wrap_start: rd/vld/adr=%b%b/%h want 10/fe", mem_rd, instr_valid, mem_adr);
    end
    tick();
    tick();
    checks++;
    if (mem_adr !== 8'h00) begin
      errors++;
      $display("FAIL wrap_adr: adr=%h want 00", mem_adr);
    end
    tick();
    tick();
    checks++;
    if ({instr_valid, instr, pc} !== {1'b1, 32'h44332211, 8'h02}) begin
      errors++;
      $display("FAIL wrap_done: vld/instr/pc=%b/%h/%h want 1/44332211/02", instr_valid, instr, pc);
    end
    en = 1'b0;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    checks++;
    if ({busy, mem_rd, instr_valid, pc} !== {1'b0, 1'b0, 1'b0, 8'h02}) begin
      errors++;
      $display("FAIL wrap_idle: busy/rd/vld/pc=%b%b%b/%h want 000/02", busy, mem_rd, instr_valid, pc);
    end
  endtask

  task automatic test_wide_and_reset();
    en16 = 1'b1;
    tick();
    checks++;
    if ({mem_rd16, mem_adr16} !== {1'b1, 8'h10}) begin
      errors++;
      $display("FAIL wide_beat0: rd/adr=%b/%h want 1/10", mem_rd16, mem_adr16);
    end
    tick();
    checks++;
    if ({instr_valid16, mem_adr16} !== {1'b0, 8'h11}) begin
      errors++;
      $display("FAIL wide_beat1: vld/adr=%b/%h want 0/11", instr_valid16, mem_adr16);
    end
    tick();
    checks++;
    if ({instr_valid16, instr16, pc16} !== {1'b1, 32'h00852020, 8'h12}) begin
      errors++;
      $display("FAIL wide_done: vld/instr/pc=%b/%h/%h want 1/00852020/12",
               instr_valid16, instr16, pc16);
    end
    instr_ready16 = 1'b1;
    en = 1'b1;
    tick();
    instr_ready16 = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({mem_rd16, instr_valid16, busy16, pc16, instr16, mem_adr16} !==
        {1'b0, 1'b0, 1'b0, 8'h10, 32'h0, 8'h10}) begin
      errors++;
      $display("FAIL wide_async_reset: rd/vld/busy/pc/instr/adr=%b%b%b/%h/%h/%h want 000/10/00000000/10",
               mem_rd16, instr_valid16, busy16, pc16, instr16, mem_adr16);
    end
    checks++;
    if ({mem_rd, instr_valid, busy, pc, instr, mem_adr} !==
        {1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 8'h00}) begin
      errors++;
      $display("FAIL async_reset8: rd/vld/busy/pc/instr/adr=%b%b%b/%h/%h/%h want 000/00/00000000/00",
               mem_rd, instr_valid, busy, pc, instr, mem_adr);
    end
    en = 1'b0;
    en16 = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; mem_ready = 1'b1; instr_ready = 1'b0;
    en16 = 1'b0; redirect16 = 1'b0; redirect_pc16 = 8'h00; mem_ready16 = 1'b1; instr_ready16 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'hEE;
      mem16[i] = 16'hEEEE;
    end
    mem[0] = 8'h20; mem[1] = 8'h20; mem[2] = 8'h85; mem[3] = 8'h00;
    mem[5] = 8'hAA;
    mem[8'h40] = 8'h01; mem[8'h41] = 8'h02; mem[8'h42] = 8'h03; mem[8'h43] = 8'h04;
    mem16[8'h10] = 16'h2020; mem16[8'h11] = 16'h0085;

    test_reset();
    test_basic_fetch();
    test_hold();
    test_stall();
    test_redirect();
    test_wrap();
    test_wide_and_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
